// File: rtl/multicycle_control_unit_if.sv
// Control/status bundle between the multi-cycle RV32I sequencer and its datapath.
// The sequencer side uses the master modport; the datapath (or a bench) uses the slave modport.
interface multicycle_control_unit_if #(
  parameter int ALUCTRL_W = 4
);
  logic [31:0]          instr;
  logic                 zero;
  logic                 lt;
  logic                 ltu;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 ir_write;
  logic                 adr_src;
  logic                 mem_read;
  logic                 mem_write;
  logic                 reg_write;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic [ALUCTRL_W-1:0] alu_ctrl;
  logic [2:0]           imm_src;
  logic [1:0]           result_src;
  logic                 illegal;
  logic [3:0]           state_o;

  modport master (
    input  instr, zero, lt, ltu, mem_ready,
    output pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
           alu_src_a, alu_src_b, alu_ctrl, imm_src, result_src, illegal, state_o
  );

  modport slave (
    output instr, zero, lt, ltu, mem_ready,
    input  pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
           alu_src_a, alu_src_b, alu_ctrl, imm_src, result_src, illegal, state_o
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences one shared ALU and one unified memory port,
// driving every datapath strobe and mux select from the current state (plus mem_ready/flags).
module multicycle_control_unit #(
  parameter int ALUCTRL_W     = 4,
  parameter bit USE_MEM_READY = 1'b1,
  parameter bit ILLEGAL_TRAP  = 1'b1
) (
  input logic                       clk,
  input logic                       rst_n,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    LINK     = 4'd12,
    UPPER    = 4'd13,
    TRAP     = 4'd14
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_SRA = 4'd9;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R    = 7'b0110011,
                         OP_I    = 7'b0010011, OP_BR    = 7'b1100011, OP_JAL  = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111;

  state_t      state;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic        f7b5;
  logic        mr;
  logic [3:0]  alu4;
  logic [ALUCTRL_W-1:0] alu_full;
  logic        unused_instr;

  assign op   = bus.instr[6:0];
  assign f3   = bus.instr[14:12];
  assign f7b5 = bus.instr[30];
  assign mr   = USE_MEM_READY ? bus.mem_ready : 1'b1;
  assign unused_instr = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  // R-type subtracts on f7[5]; I-type never does, but both honour it for the right shift.
  function automatic logic [3:0] alu_map(input logic [2:0] fn3, input logic b30, input logic is_r);
    case (fn3)
      3'b000:  alu_map = (is_r && b30) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_map = ALU_SLL;
      3'b010:  alu_map = ALU_SLT;
      3'b011:  alu_map = ALU_SLTU;
      3'b100:  alu_map = ALU_XOR;
      3'b101:  alu_map = b30 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_map = ALU_OR;
      default: alu_map = ALU_AND;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] fn3, input logic z, input logic l, input logic lu);
    case (fn3)
      3'b000:  br_taken = z;
      3'b001:  br_taken = !z;
      3'b100:  br_taken = l;
      3'b101:  br_taken = !l;
      3'b110:  br_taken = lu;
      3'b111:  br_taken = !lu;
      default: br_taken = 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [6:0] opc, input logic [2:0] fn3);
    case (opc)
      OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_illegal = 1'b0;
      OP_BR:   is_illegal = (fn3 == 3'b010) || (fn3 == 3'b011);
      default: is_illegal = 1'b1;
    endcase
  endfunction

  function automatic state_t decode_next(input logic [6:0] opc, input logic [2:0] fn3);
    if (is_illegal(opc, fn3)) begin
      decode_next = ILLEGAL_TRAP ? TRAP : FETCH;
    end else begin
      case (opc)
        OP_LOAD, OP_STORE: decode_next = MEMADR;
        OP_R:              decode_next = EXECR;
        OP_I:              decode_next = EXECI;
        OP_BR:             decode_next = BRANCH;
        OP_JAL:            decode_next = JAL;
        OP_JALR:           decode_next = JALR;
        default:           decode_next = UPPER;
      endcase
    end
  endfunction

  function automatic logic [2:0] imm_decode(input logic [6:0] opc);
    case (opc)
      OP_STORE:          imm_decode = 3'b001;
      OP_BR:             imm_decode = 3'b010;
      OP_JAL:            imm_decode = 3'b011;
      OP_LUI, OP_AUIPC:  imm_decode = 3'b100;
      default:           imm_decode = 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    if (mr) state <= DECODE;
        DECODE:   state <= decode_next(op, f3);
        MEMADR:   state <= op[5] ? MEMWRITE : MEMREAD;
        MEMREAD:  if (mr) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: if (mr) state <= FETCH;
        EXECR:    state <= ALUWB;
        EXECI:    state <= ALUWB;
        ALUWB:    state <= FETCH;
        BRANCH:   state <= FETCH;
        JAL:      state <= ALUWB;
        JALR:     state <= LINK;
        LINK:     state <= ALUWB;
        UPPER:    state <= ALUWB;
        TRAP:     state <= TRAP;
        default:  state <= FETCH;
      endcase
    end
  end

  // Outputs follow the state; FETCH/BRANCH strobes also fold in mem_ready and the ALU flags.
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.adr_src    = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.result_src = 2'b00;
    bus.illegal    = 1'b0;
    alu4           = ALU_ADD;
    case (state)
      FETCH: begin
        bus.mem_read   = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        bus.ir_write   = mr;
        bus.pc_write   = mr;
      end
      DECODE: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        bus.illegal   = is_illegal(op, f3);
      end
      MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
      end
      MEMREAD: begin
        bus.adr_src  = 1'b1;
        bus.mem_read = 1'b1;
      end
      MEMWB: begin
        bus.result_src = 2'b01;
        bus.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        bus.adr_src   = 1'b1;
        bus.mem_write = 1'b1;
      end
      EXECR: begin
        bus.alu_src_a = 2'b10;
        alu4          = alu_map(f3, f7b5, 1'b1);
      end
      EXECI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        alu4          = alu_map(f3, f7b5, 1'b0);
      end
      ALUWB: bus.reg_write = 1'b1;
      BRANCH: begin
        bus.alu_src_a = 2'b10;
        alu4          = ALU_SUB;
        bus.pc_write  = br_taken(f3, bus.zero, bus.lt, bus.ltu);
      end
      JAL: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.pc_write  = 1'b1;
      end
      JALR: begin
        bus.alu_src_a  = 2'b10;
        bus.alu_src_b  = 2'b01;
        bus.result_src = 2'b10;
        bus.pc_write   = 1'b1;
      end
      LINK: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
      end
      UPPER: begin
        bus.alu_src_a = op[5] ? 2'b11 : 2'b01;
        bus.alu_src_b = 2'b01;
      end
      TRAP:    bus.illegal = 1'b1;
      default: ;
    endcase
    // Reset must silence the FETCH read request immediately, not at the next edge.
    if (!rst_n) begin
      bus.pc_write  = 1'b0;
      bus.ir_write  = 1'b0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.reg_write = 1'b0;
      bus.illegal   = 1'b0;
    end
    alu_full      = '0;
    alu_full[3:0] = alu4;
  end

  assign bus.alu_ctrl = alu_full;
  assign bus.imm_src  = imm_decode(op);
  assign bus.state_o  = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: the driver queues hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_control_unit;

  logic clk;
  logic rst_n;

  multicycle_control_unit_if #(.ALUCTRL_W(4)) bus ();

  multicycle_control_unit #(
    .ALUCTRL_W(4), .USE_MEM_READY(1'b1), .ILLEGAL_TRAP(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector: {state, pcw, irw, mrd, mwr, rw, ill, adr, a, b, alu, imm, rs}
  typedef struct {
    string       tag;
    logic [23:0] v;
    bit          care;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   care   = 1'b0;

  function automatic logic [23:0] mk(input logic [3:0] st, input logic [4:0] strb, input logic ill,
                                     input logic adr, input logic [1:0] a, input logic [1:0] b,
                                     input logic [3:0] alu, input logic [2:0] imm, input logic [1:0] rs);
    mk = {st, strb, ill, adr, a, b, alu, imm, rs};
  endfunction

  function automatic logic [23:0] e_f(input logic [2:0] imm);
    e_f = mk(4'd0, 5'b11100, 1'b0, 1'b0, 2'd0, 2'd2, 4'd0, imm, 2'd2);
  endfunction
  function automatic logic [23:0] e_fw(input logic [2:0] imm);
    e_fw = mk(4'd0, 5'b00100, 1'b0, 1'b0, 2'd0, 2'd2, 4'd0, imm, 2'd2);
  endfunction
  function automatic logic [23:0] e_d(input logic [2:0] imm);
    e_d = mk(4'd1, 5'b00000, 1'b0, 1'b0, 2'd1, 2'd1, 4'd0, imm, 2'd0);
  endfunction
  function automatic logic [23:0] e_wb(input logic [2:0] imm);
    e_wb = mk(4'd8, 5'b00001, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, imm, 2'd0);
  endfunction

  // in4 = {zero, lt, ltu, mem_ready}; one call covers exactly one clock cycle.
  task automatic cyc(input string tag, input logic [31:0] ins, input logic [3:0] in4, input logic [23:0] e);
    exp_t x;
    bus.instr     = ins;
    bus.zero      = in4[3];
    bus.lt        = in4[2];
    bus.ltu       = in4[1];
    bus.mem_ready = in4[0];
    x.tag  = tag;
    x.v    = e;
    x.care = care;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  logic [23:0] act;
  assign act = {bus.state_o, bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write,
                bus.illegal, bus.adr_src, bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl, bus.imm_src,
                bus.result_src};

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t        x;
      logic [23:0] m;
      x = sb.pop_front();
      m = x.care ? 24'hFFFFFF : 24'hFFC000;
      checks++;
      if ((act & m) !== (x.v & m)) begin
        errors++;
        $display("FAIL %s: got %h want %h (mask %h)", x.tag, act & m, x.v & m, m);
      end
    end
  end

  localparam logic [31:0] I_ADDI  = 32'h00500093, I_SRAI = 32'h4030D093, I_ADDN = 32'hC0008093,
                          I_SUB   = 32'h402081B3, I_ADD  = 32'h002081B3, I_LW   = 32'h00802283,
                          I_BNE   = 32'h00209463, I_BGE  = 32'h0020D463, I_BLTU = 32'h0020E463,
                          I_BBAD  = 32'h0020A463, I_JALR = 32'h000280E7, I_JAL  = 32'h008000EF,
                          I_LUI   = 32'h123450B7, I_SW   = 32'h00202223;

  localparam logic [23:0] E_RST = 24'h000000;

  initial begin
    rst_n = 1'b0;
    bus.instr = 32'h0; bus.zero = 1'b0; bus.lt = 1'b0; bus.ltu = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    care = 1'b0;
    cyc("reset", I_ADDI, 4'b0001, E_RST);
    rst_n = 1'b1;
    care = 1'b1;

    // I-type: addi, srai, addi with bit30 set (must stay add)
    cyc("addi_F",  I_ADDI, 4'b0001, e_f(3'd0));
    cyc("addi_D",  I_ADDI, 4'b0001, e_d(3'd0));
    cyc("addi_EX", I_ADDI, 4'b0001, mk(4'd7, 5'b00000, 0, 0, 2'd2, 2'd1, 4'd0, 3'd0, 2'd0));
    cyc("addi_WB", I_ADDI, 4'b0001, e_wb(3'd0));
    cyc("srai_F",  I_SRAI, 4'b0001, e_f(3'd0));
    cyc("srai_D",  I_SRAI, 4'b0001, e_d(3'd0));
    cyc("srai_EX", I_SRAI, 4'b0001, mk(4'd7, 5'b00000, 0, 0, 2'd2, 2'd1, 4'd9, 3'd0, 2'd0));
    cyc("srai_WB", I_SRAI, 4'b0001, e_wb(3'd0));
    cyc("addn_F",  I_ADDN, 4'b0001, e_f(3'd0));
    cyc("addn_D",  I_ADDN, 4'b0001, e_d(3'd0));
    cyc("addn_EX", I_ADDN, 4'b0001, mk(4'd7, 5'b00000, 0, 0, 2'd2, 2'd1, 4'd0, 3'd0, 2'd0));
    cyc("addn_WB", I_ADDN, 4'b0001, e_wb(3'd0));

    // R-type sub/add
    cyc("sub_F",  I_SUB, 4'b0001, e_f(3'd0));
    cyc("sub_D",  I_SUB, 4'b0001, e_d(3'd0));
    cyc("sub_EX", I_SUB, 4'b0001, mk(4'd6, 5'b00000, 0, 0, 2'd2, 2'd0, 4'd1, 3'd0, 2'd0));
    cyc("sub_WB", I_SUB, 4'b0001, e_wb(3'd0));
    cyc("add_F",  I_ADD, 4'b0001, e_f(3'd0));
    cyc("add_D",  I_ADD, 4'b0001, e_d(3'd0));
    cyc("add_EX", I_ADD, 4'b0001, mk(4'd6, 5'b00000, 0, 0, 2'd2, 2'd0, 4'd0, 3'd0, 2'd0));
    cyc("add_WB", I_ADD, 4'b0001, e_wb(3'd0));

    // Load with 2 fetch wait cycles and 3 memread wait cycles: 10 cycles total
    cyc("lw_Fw1", I_LW, 4'b0000, e_fw(3'd0));
    cyc("lw_Fw2", I_LW, 4'b0000, e_fw(3'd0));
    cyc("lw_F",   I_LW, 4'b0001, e_f(3'd0));
    cyc("lw_D",   I_LW, 4'b0001, e_d(3'd0));
    cyc("lw_ADR", I_LW, 4'b0001, mk(4'd2, 5'b00000, 0, 0, 2'd2, 2'd1, 4'd0, 3'd0, 2'd0));
    for (int i = 0; i < 3; i++)
      cyc("lw_RDw", I_LW, 4'b0000, mk(4'd3, 5'b00100, 0, 1, 2'd0, 2'd0, 4'd0, 3'd0, 2'd0));
    cyc("lw_RD",  I_LW, 4'b0001, mk(4'd3, 5'b00100, 0, 1, 2'd0, 2'd0, 4'd0, 3'd0, 2'd0));
    cyc("lw_WB",  I_LW, 4'b0001, mk(4'd4, 5'b00001, 0, 0, 2'd0, 2'd0, 4'd0, 3'd0, 2'd1));

    // Branches
    cyc("bne_F",  I_BNE, 4'b1001, e_f(3'd2));
    cyc("bne_D",  I_BNE, 4'b1001, e_d(3'd2));
    cyc("bne_BR", I_BNE, 4'b1001, mk(4'd9, 5'b00000, 0, 0, 2'd2, 2'd0, 4'd1, 3'd2, 2'd0));
    cyc("bge_F",  I_BGE, 4'b0101, e_f(3'd2));
    cyc("bge_D",  I_BGE, 4'b0101, e_d(3'd2));
    cyc("bge_BR", I_BGE, 4'b0101, mk(4'd9, 5'b00000, 0, 0, 2'd2, 2'd0, 4'd1, 3'd2, 2'd0));
    cyc("bltu_F",  I_BLTU, 4'b0011, e_f(3'd2));
    cyc("bltu_D",  I_BLTU, 4'b0011, e_d(3'd2));
    cyc("bltu_BR", I_BLTU, 4'b0011, mk(4'd9, 5'b10000, 0, 0, 2'd2, 2'd0, 4'd1, 3'd2, 2'd0));

    // JALR, JAL, LUI
    cyc("jalr_F",  I_JALR, 4'b0001, e_f(3'd0));
    cyc("jalr_D",  I_JALR, 4'b0001, e_d(3'd0));
    cyc("jalr_J",  I_JALR, 4'b0001, mk(4'd11, 5'b10000, 0, 0, 2'd2, 2'd1, 4'd0, 3'd0, 2'd2));
    cyc("jalr_LK", I_JALR, 4'b0001, mk(4'd12, 5'b00000, 0, 0, 2'd1, 2'd2, 4'd0, 3'd0, 2'd0));
    cyc("jalr_WB", I_JALR, 4'b0001, e_wb(3'd0));
    cyc("jal_F",  I_JAL, 4'b0001, e_f(3'd3));
    cyc("jal_D",  I_JAL, 4'b0001, e_d(3'd3));
    cyc("jal_J",  I_JAL, 4'b0001, mk(4'd10, 5'b10000, 0, 0, 2'd1, 2'd2, 4'd0, 3'd3, 2'd0));
    cyc("jal_WB", I_JAL, 4'b0001, e_wb(3'd3));
    cyc("lui_F",  I_LUI, 4'b0001, e_f(3'd4));
    cyc("lui_D",  I_LUI, 4'b0001, e_d(3'd4));
    cyc("lui_U",  I_LUI, 4'b0001, mk(4'd13, 5'b00000, 0, 0, 2'd3, 2'd1, 4'd0, 3'd4, 2'd0));
    cyc("lui_WB", I_LUI, 4'b0001, e_wb(3'd4));

    // Store aborted by reset while waiting on memory
    cyc("sw_F",   I_SW, 4'b0001, e_f(3'd1));
    cyc("sw_D",   I_SW, 4'b0001, e_d(3'd1));
    cyc("sw_ADR", I_SW, 4'b0001, mk(4'd2, 5'b00000, 0, 0, 2'd2, 2'd1, 4'd0, 3'd1, 2'd0));
    cyc("sw_WRw", I_SW, 4'b0000, mk(4'd5, 5'b00010, 0, 1, 2'd0, 2'd0, 4'd0, 3'd1, 2'd0));
    cyc("sw_WRw", I_SW, 4'b0000, mk(4'd5, 5'b00010, 0, 1, 2'd0, 2'd0, 4'd0, 3'd1, 2'd0));
    rst_n = 1'b0;
    care  = 1'b0;
    cyc("sw_rst", I_SW, 4'b0000, E_RST);
    rst_n = 1'b1;
    care  = 1'b1;
    cyc("sw_postF", I_SW, 4'b0001, e_f(3'd1));
    cyc("sw_postD", I_SW, 4'b0001, e_d(3'd1));

    // Illegal branch funct3 (from DECODE of the sw, go through a fresh fetch first)
    cyc("sw2_ADR", I_SW, 4'b0001, mk(4'd2, 5'b00000, 0, 0, 2'd2, 2'd1, 4'd0, 3'd1, 2'd0));
    cyc("sw2_WR",  I_SW, 4'b0001, mk(4'd5, 5'b00010, 0, 1, 2'd0, 2'd0, 4'd0, 3'd1, 2'd0));
    cyc("bad_F", I_BBAD, 4'b0001, e_f(3'd2));
    cyc("bad_D", I_BBAD, 4'b0001, mk(4'd1, 5'b00000, 1, 0, 2'd1, 2'd1, 4'd0, 3'd2, 2'd0));
    for (int i = 0; i < 3; i++)
      cyc("trap", I_BBAD, 4'b0001, mk(4'd14, 5'b00000, 1, 0, 2'd0, 2'd0, 4'd0, 3'd2, 2'd0));
    rst_n = 1'b0;
    care  = 1'b0;
    cyc("trap_rst", I_BBAD, 4'b0001, E_RST);
    rst_n = 1'b1;
    care  = 1'b1;
    cyc("trap_postF", I_ADDI, 4'b0001, e_f(3'd0));

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
